// File: rtl/multicycle_main_control.sv
// Multicycle LEGv8 main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives ALUOp plus datapath enables. Define MCC_PERF_COUNTERS_EN for cycle/retire counters.
module multicycle_main_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_source,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        reg2loc,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [3:0]  state
`ifdef MCC_PERF_COUNTERS_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_retired
`endif
);

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_CBZ      = 4'd9,
        S_BRANCH   = 4'd10,
        S_FAULT    = 4'd15
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    state_t            state_q, state_next;
    logic [1:0]        fault_code_q, code_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait, timeout;
    logic              is_ldur, is_stur, is_rfmt, is_cbz, is_b;

    // The zero flag qualifies pc_write_cond inside the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    assign is_ldur = (opcode == 11'b11111000010);
    assign is_stur = (opcode == 11'b11111000000);
    assign is_rfmt = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                     (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
    assign is_cbz  = (opcode[10:3] == 8'b10110100);
    assign is_b    = (opcode[10:5] == 6'b000101);

    assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // Ready on the limit cycle wins over the timeout.
    assign timeout  = (MEM_TIMEOUT > 0) && mem_wait && !mem_ready && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        state_next = state_q;
        code_next  = fault_code_q;
        case (state_q)
            S_START:  state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) state_next = S_DECODE;
                else if (timeout) begin
                    state_next = S_FAULT;
                    code_next  = 2'b10;
                end
            end
            S_DECODE: begin
                if (is_ldur || is_stur) state_next = S_MEM_ADDR;
                else if (is_rfmt)       state_next = S_R_EXEC;
                else if (is_cbz)        state_next = S_CBZ;
                else if (is_b)          state_next = S_BRANCH;
                else begin
                    state_next = S_FAULT;
                    code_next  = 2'b01;
                end
            end
            S_MEM_ADDR: begin
                if (is_ldur)      state_next = S_MEM_RD;
                else if (is_stur) state_next = S_MEM_WR;
                else begin
                    state_next = S_FAULT;
                    code_next  = 2'b01;
                end
            end
            S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) state_next = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                else if (timeout) begin
                    state_next = S_FAULT;
                    code_next  = 2'b10;
                end
            end
            S_MEM_WB, S_R_WB, S_CBZ, S_BRANCH: state_next = S_FETCH;
            S_R_EXEC: state_next = S_R_WB;
            S_FAULT:  state_next = S_FAULT;
            default:  state_next = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_START;
            fault_code_q <= 2'b00;
            wait_cnt     <= '0;
        end else begin
            state_q      <= state_next;
            fault_code_q <= code_next;
            if (state_next != state_q)
                wait_cnt <= '0;
            else if (mem_wait && !mem_ready && (wait_cnt != '1))
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_comb begin
        alu_op        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg2loc       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                reg2loc   = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_R_WB: reg_write = 1'b1;
            S_CBZ: begin
                reg2loc       = 1'b1;
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
            end
            S_BRANCH: begin
                pc_write  = 1'b1;
                pc_source = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault      = (state_q == S_FAULT);
    assign fault_code = fault_code_q;
    assign state      = state_q;

`ifdef MCC_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count   <= '0;
            instr_retired <= '0;
        end else begin
            if ((state_q != S_START) && (state_q != S_FAULT))
                cycle_count <= cycle_count + CNT_WIDTH'(1);
            // A return to FETCH from anywhere but START marks a completed instruction.
            if ((state_next == S_FETCH) && (state_q != S_FETCH) && (state_q != S_START))
                instr_retired <= instr_retired + CNT_WIDTH'(1);
        end
    end
`else
    localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: per-cycle output vectors checked through a scoreboard.
module tb_multicycle_main_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [1:0]  alu_op, alu_src_b, fault_code;
    logic        alu_src_a, iord, mem_read, mem_write, ir_write, pc_write, pc_write_cond;
    logic        pc_source, reg_write, mem_to_reg, reg2loc, fault;
    logic [3:0]  state;
`ifdef MCC_PERF_COUNTERS_EN
    logic [31:0] cycle_count, instr_retired;
`endif

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    multicycle_main_control #(.MEM_TIMEOUT(15), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_source(pc_source), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .reg2loc(reg2loc), .fault(fault), .fault_code(fault_code),
        .state(state)
`ifdef MCC_PERF_COUNTERS_EN
        , .cycle_count(cycle_count), .instr_retired(instr_retired)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [21:0] vec;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference output table: {state, alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write,
    // ir_write, pc_write, pc_write_cond, pc_source, reg_write, mem_to_reg, reg2loc, fault, fault_code}
    function automatic logic [21:0] model(input logic [3:0] s, input logic mr, input logic [1:0] fc);
        logic [1:0] aop, asb;
        logic asa, io, mrd, mwr, irw, pcw, pcc, pcs, rw, m2r, r2l, flt;
        aop = 2'b00; asb = 2'b00;
        asa = 0; io = 0; mrd = 0; mwr = 0; irw = 0; pcw = 0; pcc = 0; pcs = 0;
        rw = 0; m2r = 0; r2l = 0; flt = 0;
        case (s)
            4'd1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd2:  asb = 2'b11;
            4'd3:  begin asa = 1; asb = 2'b10; end
            4'd4:  begin mrd = 1; io = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mwr = 1; io = 1; r2l = 1; end
            4'd7:  begin asa = 1; aop = 2'b10; end
            4'd8:  rw = 1;
            4'd9:  begin r2l = 1; asa = 1; aop = 2'b01; pcc = 1; pcs = 1; end
            4'd10: begin pcw = 1; pcs = 1; end
            4'd15: flt = 1;
            default: ;
        endcase
        return {s, aop, asa, asb, io, mrd, mwr, irw, pcw, pcc, pcs, rw, m2r, r2l, flt, fc};
    endfunction

    function automatic logic [21:0] observed();
        return {state, alu_op, alu_src_a, alu_src_b, iord, mem_read, mem_write, ir_write,
                pc_write, pc_write_cond, pc_source, reg_write, mem_to_reg, reg2loc, fault, fault_code};
    endfunction

    task automatic expect_out(input logic [3:0] s, input logic mr, input logic [1:0] fc, input string tag);
        exp_t e;
        e.tag = tag;
        e.vec = model(s, mr, fc);
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic [21:0] obs;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=%h required=entry", observed());
        end else begin
            e = sb.pop_front();
            obs = observed();
            assert (obs === e.vec) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
            end
        end
    endtask

    // One clock cycle: drive inputs, record expectation for the current state, compare mid-cycle.
    task automatic cyc(input logic mr, input logic [10:0] op, input logic [3:0] es,
                       input logic [1:0] ec, input string tag);
        mem_ready = mr;
        opcode    = op;
        expect_out(es, mr, ec, tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #2;
        expect_out(4'd0, mem_ready, 2'b00, tag);
        check_out();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        pulse_reset("reset_state");
        cyc(1, OP_ADD, 4'd0, 2'b00, "start");

        // ADD then B; counters checked on the second return to FETCH
        cyc(1, OP_ADD, 4'd1, 2'b00, "add_fetch");
        cyc(1, OP_ADD, 4'd2, 2'b00, "add_decode");
        cyc(1, OP_ADD, 4'd7, 2'b00, "add_rexec");
        cyc(1, OP_ADD, 4'd8, 2'b00, "add_rwb");
        cyc(1, OP_B,   4'd1, 2'b00, "b_fetch");
        cyc(1, OP_B,   4'd2, 2'b00, "b_decode");
        cyc(1, OP_B,   4'd10, 2'b00, "b_branch");
`ifdef MCC_PERF_COUNTERS_EN
        total++;
        assert (cycle_count === 32'd7) else begin
            bad++;
            $error("FAIL cycle_count observed=%0d expected=7", cycle_count);
        end
        total++;
        assert (instr_retired === 32'd2) else begin
            bad++;
            $error("FAIL instr_retired observed=%0d expected=2", instr_retired);
        end
`endif

        // LDUR with three stall cycles in MEM_RD
        cyc(1, OP_LDUR, 4'd1, 2'b00, "ldur_fetch");
        cyc(1, OP_LDUR, 4'd2, 2'b00, "ldur_decode");
        cyc(1, OP_LDUR, 4'd3, 2'b00, "ldur_memaddr");
        for (int i = 0; i < 3; i++) cyc(0, OP_BAD, 4'd4, 2'b00, "ldur_memrd_stall");
        cyc(1, OP_BAD, 4'd4, 2'b00, "ldur_memrd_done");
        cyc(1, OP_BAD, 4'd5, 2'b00, "ldur_memwb");

        // STUR
        cyc(1, OP_STUR, 4'd1, 2'b00, "stur_fetch");
        cyc(1, OP_STUR, 4'd2, 2'b00, "stur_decode");
        cyc(1, OP_STUR, 4'd3, 2'b00, "stur_memaddr");
        cyc(1, OP_STUR, 4'd6, 2'b00, "stur_memwr");

        // CBZ
        cyc(1, OP_CBZ, 4'd1, 2'b00, "cbz_fetch");
        cyc(1, OP_CBZ, 4'd2, 2'b00, "cbz_decode");
        cyc(1, OP_CBZ, 4'd9, 2'b00, "cbz_exec");

        // ORR, then FETCH ready on the 15th (limit) cycle completes normally
        cyc(1, OP_ORR, 4'd1, 2'b00, "orr_fetch");
        cyc(1, OP_ORR, 4'd2, 2'b00, "orr_decode");
        cyc(1, OP_ORR, 4'd7, 2'b00, "orr_rexec");
        cyc(1, OP_ORR, 4'd8, 2'b00, "orr_rwb");
        for (int i = 0; i < 14; i++) cyc(0, OP_ADD, 4'd1, 2'b00, "fetch_wait");
        cyc(1, OP_ADD, 4'd1, 2'b00, "fetch_ready_at_limit");
        cyc(1, OP_ADD, 4'd2, 2'b00, "decode_after_limit");
        cyc(1, OP_ADD, 4'd7, 2'b00, "rexec_after_limit");
        cyc(1, OP_ADD, 4'd8, 2'b00, "rwb_after_limit");

        // FETCH stuck: FAULT after 15 FETCH cycles, sticky
        for (int i = 0; i < 15; i++) cyc(0, OP_ADD, 4'd1, 2'b00, "fetch_stuck");
        cyc(1, OP_ADD, 4'd15, 2'b10, "fetch_timeout_fault");
        cyc(1, OP_B,   4'd15, 2'b10, "fault_sticky");
        pulse_reset("reset_from_timeout");
        cyc(1, OP_ADD, 4'd0, 2'b00, "start_after_timeout");

        // Illegal opcode
        cyc(1, OP_BAD, 4'd1, 2'b00, "bad_fetch");
        cyc(1, OP_BAD, 4'd2, 2'b00, "bad_decode");
        cyc(1, OP_ADD, 4'd15, 2'b01, "illegal_fault");
        cyc(0, OP_LDUR, 4'd15, 2'b01, "illegal_sticky");
        pulse_reset("reset_from_illegal");
        cyc(1, OP_ADD, 4'd0, 2'b00, "start_after_illegal");

        // STUR with memory timeout in MEM_WR
        cyc(1, OP_STUR, 4'd1, 2'b00, "sturto_fetch");
        cyc(1, OP_STUR, 4'd2, 2'b00, "sturto_decode");
        cyc(1, OP_STUR, 4'd3, 2'b00, "sturto_memaddr");
        for (int i = 0; i < 15; i++) cyc(0, OP_STUR, 4'd6, 2'b00, "memwr_stuck");
        cyc(0, OP_STUR, 4'd15, 2'b10, "memwr_timeout_fault");
        pulse_reset("reset_from_memwr");
        cyc(1, OP_LDUR, 4'd0, 2'b00, "start_before_abort");

        // Asynchronous reset mid-read drops every output immediately
        cyc(1, OP_LDUR, 4'd1, 2'b00, "abort_fetch");
        cyc(1, OP_LDUR, 4'd2, 2'b00, "abort_decode");
        cyc(1, OP_LDUR, 4'd3, 2'b00, "abort_memaddr");
        cyc(0, OP_LDUR, 4'd4, 2'b00, "abort_memrd");
        pulse_reset("async_abort");
        cyc(1, OP_ADD, 4'd0, 2'b00, "start_after_abort");
        cyc(0, OP_ADD, 4'd1, 2'b00, "fetch_after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Multicycle LEGv8 main control FSM. Sits directly upstream of the ALU control decoder.
- Consumes the 11-bit instruction opcode from the instruction register and the ALU zero flag.
- Produces ALUOp for the ALU control decoder, plus all datapath enables and mux selects.
- Sequences each instruction through fetch/decode/execute/memory/writeback states, with memory ready handshake and timeout.

Parameters:
MEM_TIMEOUT, 15, max cycles waiting on mem_ready in a memory state before FAULT; 0 disables timeout
CNT_WIDTH, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  11  instruction bits [31:21] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current read/write this cycle
alu_op  out  2  to ALU control: 00 add, 01 pass-B/branch, 10 R-format
alu_src_a  out  1  0=PC, 1=register A
alu_src_b  out  2  00=register B, 01=const 4, 10=sign-ext imm, 11=branch offset<<2
iord  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  load instruction register
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero=1
pc_source  out  1  0=ALU result, 1=ALUOut
reg_write  out  1  register file write
mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
reg2loc  out  1  read-reg-2 select: 1=Rt field
fault  out  1  FSM in FAULT
fault_code  out  2  01 illegal opcode, 10 memory timeout, 00 none
state  out  4  current state encoding (debug)

Behaviour:
- Moore FSM, 4-bit state register. Outputs are combinational from state; memory-state enables are additionally gated by mem_ready where noted.
- Encodings: START=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, R_EXEC=7, R_WB=8, CBZ=9, BRANCH=10, FAULT=15.
- Reset (rst_n low, asynchronous): state=START, wait counter=0, fault_code=00. All outputs 0.
- START: outputs 0. Goes to FETCH next cycle.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target to ALUOut). Next state by opcode:
  - 11111000010 (LDUR) or 11111000000 (STUR) -> MEM_ADDR
  - 10001011000 (ADD), 11001011000 (SUB), 10001010000 (AND), 10101010000 (ORR) -> R_EXEC
  - opcode[10:3]=10110100 (CBZ) -> CBZ
  - opcode[10:5]=000101 (B) -> BRANCH
  - anything else -> FAULT, fault_code=01
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. LDUR -> MEM_RD; STUR -> MEM_WR.
- MEM_RD: mem_read=1, iord=1. mem_ready=1 -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. -> FETCH.
- MEM_WR: mem_write=1, iord=1, reg2loc=1. mem_ready=1 -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. -> R_WB.
- R_WB: reg_write=1, mem_to_reg=0. -> FETCH.
- CBZ: reg2loc=1, alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1. -> FETCH.
- BRANCH: pc_write=1, pc_source=1. -> FETCH.
- FAULT: all enables 0, fault=1, alu_op=00. Sticky until rst_n.
- Opcode is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.
- Cycle counts: R-format 4, LDUR 5, STUR 4, CBZ 3, B 3, assuming mem_ready=1 on the first cycle of each memory state.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle in those states while mem_ready=0.
  - Counter == MEM_TIMEOUT-1 with mem_ready=0 -> FAULT, fault_code=10.
  - mem_ready=1 on the limit cycle completes normally (ready wins).
  - Saturates; never wraps.
- rst_n assertion mid-instruction aborts immediately. No partial write is held: outputs drop to 0 asynchronously.

Optional Feature:
- Macro MCC_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs cycle_count[CNT_WIDTH-1:0] and instr_retired[CNT_WIDTH-1:0], both reset to 0.
  - cycle_count increments every cycle outside START/FAULT.
  - instr_retired increments on each transition into FETCH from any non-START state.
  - Both wrap modulo 2^CNT_WIDTH.
- Undefined: these ports and their logic are absent.

Test Plan:
- Reset then ADD opcode 10001011000, mem_ready=1 -> states 0,1,2,7,8,1. alu_op=10 only in R_EXEC. reg_write=1 one cycle in R_WB.
- LDUR 11111000010, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles. MEM_WB asserts reg_write=1, mem_to_reg=1. No fault.
- CBZ 10110100101 -> CBZ state drives alu_op=01, pc_write_cond=1, pc_source=1, reg2loc=1. Then FETCH.
- Opcode 11111111111 in DECODE -> FAULT, fault=1, fault_code=01. Holds until rst_n pulse, then START.
- MEM_TIMEOUT=15, mem_ready stuck 0 in FETCH -> FAULT after 15 FETCH cycles, fault_code=10. Repeat with mem_ready=1 on 15th cycle -> DECODE, no fault.
- MCC_PERF_COUNTERS_EN defined, run ADD then B -> instr_retired=2, cycle_count=7 at second return to FETCH.
